// File: rtl/kmkz_barrel_shifter.sv
// kmkz_barrel_shifter
// Two-stage pipelined barrel shifter for the Kamikaze execute/writeback path.
// Stage 1 resolves the top S1_BITS shamt bits and registers the partial result.
// Stage 2 resolves the remaining low shamt bits combinationally into writeback.
//
// Ports:
//   clk_i      clock, all state on rising edge
//   rst_i      synchronous active-high reset
//   x_stall_i  execute stall, holds the stage-2 registers
//   x_kill_i   flush, invalidates the op being captured this edge
//   d_valid_i  operand valid
//   d_rs1_i    operand (XLEN)
//   d_shamt_i  shift amount (SHW)
//   d_op_i     000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, others reserved
//   d_word_i   RV64 32-bit word op (ignored when XLEN=32)
//   d_tag_i    destination tag
//   w_valid_o  result valid
//   w_rd_o     result (XLEN)
//   w_tag_o    tag of result
module kmkz_barrel_shifter #(
  parameter int XLEN    = 32,
  parameter int SHW     = $clog2(XLEN),
  parameter int S1_BITS = 2,
  parameter int TAGW    = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            x_stall_i,
  input  logic            x_kill_i,
  input  logic            d_valid_i,
  input  logic [XLEN-1:0] d_rs1_i,
  input  logic [SHW-1:0]  d_shamt_i,
  input  logic [2:0]      d_op_i,
  input  logic            d_word_i,
  input  logic [TAGW-1:0] d_tag_i,
  output logic            w_valid_o,
  output logic [XLEN-1:0] w_rd_o,
  output logic [TAGW-1:0] w_tag_o
);

  localparam int S2_BITS = SHW - S1_BITS;
  localparam bit WORD_EN = (XLEN == 64);

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  // Bit reversal within the effective width; in word mode the upper half is zeroed.
  function automatic logic [XLEN-1:0] rev_w(input logic [XLEN-1:0] v, input logic word);
    logic [XLEN-1:0] r;
    r = '0;
    if (word) begin
      for (int i = 0; i < 32; i++) r[i] = v[31-i];
    end else begin
      for (int i = 0; i < XLEN; i++) r[i] = v[XLEN-1-i];
    end
    return r;
  endfunction

  // One right-shift step by a constant k. The vacated top k bits come either from
  // the wrapped-out low bits (rotate) or from the fill bit. In word mode only the
  // low 32 bits take part, so bits [63:32] can never rotate into the result.
  function automatic logic [XLEN-1:0] rstep(input logic [XLEN-1:0] v, input int k,
                                            input logic rot, input logic fill,
                                            input logic word);
    logic [XLEN-1:0] fv;
    logic [XLEN-1:0] r;
    logic [31:0]     lo;
    logic [31:0]     f32;
    fv  = rot ? v : {XLEN{fill}};
    lo  = v[31:0];
    f32 = rot ? lo : {32{fill}};
    r   = '0;
    if (word) r[31:0] = (lo >> k) | (f32 << (32 - k));
    else      r = (v >> k) | (fv << (XLEN - k));
    return r;
  endfunction

  // Stage 1 (combinational, from inputs)
  logic               word_eff;
  logic               s1_rot;
  logic               s1_left;
  logic               s1_fill;
  logic [SHW-1:0]     s1_amt;
  logic [XLEN-1:0]    s1_v;

  // Left ops are folded into the right-shift core by reversing the operand here;
  // the register holds the reversed partial result and stage 2 reverses it back.
  always_comb begin
    word_eff = WORD_EN & d_word_i;
    s1_rot   = (d_op_i == OP_ROL) || (d_op_i == OP_ROR);
    s1_left  = (d_op_i == OP_SLL) || (d_op_i == OP_ROL);
    s1_fill  = (d_op_i == OP_SRA) & (word_eff ? d_rs1_i[31] : d_rs1_i[XLEN-1]);
    s1_amt   = d_shamt_i;
    for (int b = 5; b < SHW; b++) begin
      if (word_eff) s1_amt[b] = 1'b0;
    end
    s1_v = '0;
    if (word_eff) s1_v[31:0] = d_rs1_i[31:0];
    else          s1_v = d_rs1_i;
    if (s1_left) s1_v = rev_w(s1_v, word_eff);
    for (int b = S2_BITS; b < SHW; b++) begin
      if (s1_amt[b]) s1_v = rstep(s1_v, 1 << b, s1_rot, s1_fill, word_eff);
    end
  end

  // Stage 2 register set
  logic               s2_valid;
  logic [XLEN-1:0]    s2_data;
  logic [TAGW-1:0]    s2_tag;
  logic [2:0]         s2_op;
  logic               s2_word;
  logic               s2_fill;
  logic [S2_BITS-1:0] s2_amt;

  // Kill clears valid even while stalled; reset beats both.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_tag   <= '0;
      s2_op    <= OP_SLL;
      s2_word  <= 1'b0;
      s2_fill  <= 1'b0;
      s2_amt   <= '0;
    end else if (!x_stall_i) begin
      s2_valid <= d_valid_i & ~x_kill_i;
      if (d_valid_i) begin
        s2_data <= s1_v;
        s2_tag  <= d_tag_i;
        s2_op   <= d_op_i;
        s2_word <= word_eff;
        s2_fill <= s1_fill;
        s2_amt  <= s1_amt[S2_BITS-1:0];
      end
    end else if (x_kill_i) begin
      s2_valid <= 1'b0;
    end
  end

  // Stage 2 (combinational into writeback)
  logic            s2_rot;
  logic            s2_left;
  logic [XLEN-1:0] s2_v;

  always_comb begin
    s2_rot  = (s2_op == OP_ROL) || (s2_op == OP_ROR);
    s2_left = (s2_op == OP_SLL) || (s2_op == OP_ROL);
    s2_v    = s2_data;
    for (int b = 0; b < S2_BITS; b++) begin
      if (s2_amt[b]) s2_v = rstep(s2_v, 1 << b, s2_rot, s2_fill, s2_word);
    end
    if (s2_left) s2_v = rev_w(s2_v, s2_word);
    // RV64 *W results are sign-extended from bit 31 for every op
    if (s2_word) begin
      for (int i = 32; i < XLEN; i++) s2_v[i] = s2_v[31];
    end
    if (s2_op > OP_ROR) s2_v = '0;
  end

  assign w_valid_o = s2_valid;
  assign w_rd_o    = s2_v;
  assign w_tag_o   = s2_tag;

endmodule

// File: doc/kmkz_barrel_shifter.md
Name: kmkz_barrel_shifter

Overview:
- Parametrised two-stage pipelined barrel shifter for the Kamikaze execute/writeback path; successor to the fixed 32-bit shifter.
- Adds XLEN 32/64, RV64 word ops (SLLW/SRLW/SRAW/RORW/ROLW), rotates (Zbb ROL/ROR), a configurable stage split, and valid/tag tracking with stall and kill.
- Stage 1 resolves the high shamt bits and registers the result. Stage 2 resolves the remaining bits combinationally into writeback.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- SHW, $clog2(XLEN), shamt width (derived; do not override).
- S1_BITS, 2, number of most-significant shamt bits resolved in stage 1; legal 1..SHW-1.
- TAGW, 5, width of the destination tag carried alongside the data.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  synchronous active-high reset.
- x_stall_i  in  1  execute stall; holds stage-2 registers.
- x_kill_i  in  1  flush; invalidates the op being captured this edge.
- d_valid_i  in  1  operand valid.
- d_rs1_i  in  XLEN  operand.
- d_shamt_i  in  SHW  shift amount.
- d_op_i  in  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR; 101-111 reserved.
- d_word_i  in  1  32-bit word op; ignored when XLEN=32.
- d_tag_i  in  TAGW  rd index / tag.
- w_valid_o  out  1  result valid.
- w_rd_o  out  XLEN  result.
- w_tag_o  out  TAGW  tag of result.

Behaviour:
- Reset, synchronous: stage-2 valid=0, data=0, tag=0, op=0. Outputs read w_valid_o=0, w_rd_o=0, w_tag_o=0 the cycle after rst_i is sampled high.
- Reset overrides stall and kill.
- Capture edge, x_stall_i=0: stage-2 valid <= d_valid_i & ~x_kill_i.
  - Data, tag, op, word and sign-fill registers load only when d_valid_i=1; otherwise they hold their previous values.
- Kill priority: x_kill_i=1 clears stage-2 valid at the edge even when x_stall_i=1. Data registers are not required to change.
- Stall: x_stall_i=1 with x_kill_i=0 holds every stage-2 register. Outputs stay stable for the whole stall.
- Latency: one edge. An operand captured at edge N appears on w_* combinationally in cycle N+1. Throughput is 1 op/cycle when not stalled.
- Effective width W:
  - W=32 when d_word_i=1 and XLEN=64; otherwise W=XLEN.
  - With W=32, only d_rs1_i[31:0] and d_shamt_i[4:0] are used; d_shamt_i[5] is ignored.
- Shift semantics, with s = effective shamt:
  - SLL: shift left, zero fill.
  - SRL: shift right, zero fill.
  - SRA: shift right, fill with operand bit W-1.
  - ROR: rotate right within W bits.
  - ROL: rotate left within W bits.
  - s=0: every op returns the operand unchanged.
- Left ops are computed by bit-reversal around the right-shift core, in both stages. Stage 1 applies shamt[SHW-1 : SHW-S1_BITS]; stage 2 applies the remaining low bits.
- Rotates fill from the wrapped-out bits. Rotate fill must stay within W: in word mode, bits [63:32] never enter the rotation.
- Word-mode result: the 32-bit result sign-extended from bit 31 to XLEN, for all ops including SRL and rotates (RV64 *W semantics).
- Reserved ops 101-111: w_rd_o = 0. w_valid_o follows the normal rules.
- No internal storage beyond the stage-2 register set; no backpressure output.

Test Plan:
- XLEN=32, reset then SRA of rs1=0x80000000, shamt=4 -> next cycle w_valid_o=1, w_rd_o=0xF8000000. Before capture: w_valid_o=0, w_rd_o=0.
- XLEN=32, back-to-back ops with the same rs1=0x12345678, one per cycle: SLL 8 -> 0x34567800; SRL 28 -> 0x00000001; ROR 4 -> 0x81234567; ROL 0 -> 0x12345678. Tags 1,2,3,4 emerge in order, one per cycle.
- XLEN=32, stall: SRL of 0xF0000000 by 31 captured, then x_stall_i=1 for 3 cycles -> w_rd_o=0x00000001 with valid=1 held all 3 cycles. Assert x_kill_i during the stall -> w_valid_o=0 next cycle.
- XLEN=64, SRAW on rs1=0xFFFFFFFF_80000000, shamt=0x21 (bit 5 ignored, s=1) -> 0xFFFFFFFF_C0000000.
  - SLLW on 0x00000000_40000000, shamt 1 -> 0xFFFFFFFF_80000000.
  - RORW on 0xAAAAAAAA_00000001, shamt 1 -> 0xFFFFFFFF_80000000.
- XLEN=64, S1_BITS=3, full-width ROL on 0x80000000_00000001, shamt 63 -> 0xC0000000_00000000. SRL 63 on the same operand -> 0x1.
- Synchronous reset mid-stream: rst_i=1 while valid ops flow and x_stall_i=1 -> next cycle w_valid_o=0, w_rd_o=0, w_tag_o=0. The first op after reset deasserts emerges one cycle after capture with the correct value; rst_i pulse not aligned to a clock edge has no effect.
